// File: rtl/spi_slave_rx.sv
// SPI mode-0, LSB-first slave receiver running entirely in the system clock domain.
// cs/sclk/mosi are oversampled and sclk edges are detected from the synchronized copies.
module spi_slave_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] dout,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_d, sclk_d;
  logic [SYNC_STAGES:0]   prime;
  logic                   armed;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      rx_shift, tx_shift;
  logic                   done;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // armed only once cs has really been seen high after reset, so a cs level
  // already low at reset release never looks like a falling edge.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d & armed;
  assign cs_rise   = cs_s & ~cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
      prime     <= '0;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
      armed     <= armed | (prime[SYNC_STAGES] & cs_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      done      <= 1'b0;
      dout      <= '0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      done      <= 1'b0;

      // A transfer in the completion cycle hands over the old word, so no overrun.
      if (done) begin
        dout     <= rx_shift;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
          miso <= 1'b0;
          if (cs_fall) begin
            tx_shift <= tx_data;
            miso     <= tx_data[0];
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {mosi_s, rx_shift[DATA_W-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              done <= 1'b1;
              miso <= 1'b0;
              if (cs_rise) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= WAIT_CS;
              end
            end
          end else if (cs_rise) begin
            frame_err <= (bit_cnt != '0);
            busy      <= 1'b0;
            miso      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_fall && bit_cnt != '0) begin
            tx_shift <= tx_shift >> 1;
            miso     <= tx_shift[1];
          end
        end
        WAIT_CS: begin
          miso <= 1'b0;
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
